// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: operation codes, pipeline state encoding and
// bit positions of the packed N/Z/C/V flag vector.
package alu_pkg;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_INC = 5;
    localparam int OP_DEC = 6;
    localparam int OP_SHR = 7;
    localparam int OP_SHL = 8;
    localparam int OP_RTR = 9;
    localparam int OP_RTL = 10;
    localparam int OP_LD  = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FULL   = 2'd1,
        ST_ADJUST = 2'd2
    } alu_state_e;

    localparam int NUM_FLAGS = 4;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;

endpackage

// File: rtl/alu_bcd_adjust.sv
// Combinational packed-BCD add/subtract over WIDTH/4 digits with a digit carry chain.
// Each digit is corrected by +6 (add, digit > 9) or -6 (subtract, digit went negative).
module alu_bcd_adjust #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] r_o,
    output logic             c_o
);

    localparam int DIGITS = WIDTH / 4;

    logic [4:0] digit;
    logic       k;

    // k is the digit carry when adding and the digit borrow when subtracting.
    always_comb begin
        r_o   = '0;
        digit = '0;
        k     = sub_i ? ~ci_i : ci_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (sub_i) begin
                digit = {1'b0, a_i[4*i +: 4]} - {1'b0, b_i[4*i +: 4]} - {4'b0000, k};
                k     = digit[4];
                if (k) begin
                    digit = digit - 5'd6;
                end
            end else begin
                digit = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0000, k};
                k     = (digit > 5'd9);
                if (k) begin
                    digit = digit + 5'd6;
                end
            end
            r_o[4*i +: 4] = digit[3:0];
        end
        c_o = sub_i ? ~k : k;
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: one-deep valid/ready ALU stage with registered result and N/Z/C/V flags.
// Define ALU_DECIMAL_EN to add the two-cycle BCD path for ADD/SUB with decimal=1.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   op_number,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output alu_state_e       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and held outputs do not change until transferred.

    alu_state_e           state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;

    logic                 accept;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     bin_r;
    logic                 bin_c;
    logic                 bin_v;

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                        input logic             c,
                                                        input logic             v);
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    always_comb begin : binary_datapath
        sum   = '0;
        bin_r = operand1;
        bin_c = carry_in;
        bin_v = 1'b0;
        case (op_number)
            OPW'(OP_ADD): begin
                sum   = {1'b0, operand1} + {1'b0, operand2} + {{WIDTH{1'b0}}, carry_in};
                bin_r = sum[WIDTH-1:0];
                bin_c = sum[WIDTH];
                bin_v = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                        (bin_r[WIDTH-1] != operand1[WIDTH-1]);
            end
            OPW'(OP_SUB): begin
                // C=1 reports "no borrow".
                sum   = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, carry_in};
                bin_r = sum[WIDTH-1:0];
                bin_c = sum[WIDTH];
                bin_v = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                        (bin_r[WIDTH-1] != operand1[WIDTH-1]);
            end
            OPW'(OP_AND): bin_r = operand1 & operand2;
            OPW'(OP_OR):  bin_r = operand1 | operand2;
            OPW'(OP_XOR): bin_r = operand1 ^ operand2;
            OPW'(OP_INC): bin_r = operand1 + WIDTH'(1);
            OPW'(OP_DEC): bin_r = operand1 - WIDTH'(1);
            OPW'(OP_SHR): begin
                bin_r = {1'b0, operand1[WIDTH-1:1]};
                bin_c = operand1[0];
            end
            OPW'(OP_SHL): begin
                bin_r = {operand1[WIDTH-2:0], 1'b0};
                bin_c = operand1[WIDTH-1];
            end
            OPW'(OP_RTR): begin
                bin_r = {carry_in, operand1[WIDTH-1:1]};
                bin_c = operand1[0];
            end
            OPW'(OP_RTL): begin
                bin_r = {operand1[WIDTH-2:0], carry_in};
                bin_c = operand1[WIDTH-1];
            end
            OPW'(OP_LD):  bin_r = operand1;
            default:      bin_r = operand1;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_FULL) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_DECIMAL_EN
    logic             dec_req;
    logic [WIDTH-1:0] adj_a_q, adj_a_d;
    logic [WIDTH-1:0] adj_b_q, adj_b_d;
    logic             adj_ci_q, adj_ci_d;
    logic             adj_sub_q, adj_sub_d;
    logic             adj_v_q, adj_v_d;
    logic [WIDTH-1:0] bcd_r;
    logic             bcd_c;

    assign dec_req = decimal &&
                     ((op_number == OPW'(OP_ADD)) || (op_number == OPW'(OP_SUB)));

    alu_bcd_adjust #(
        .WIDTH (WIDTH)
    ) u_bcd_adjust (
        .a_i   (adj_a_q),
        .b_i   (adj_b_q),
        .ci_i  (adj_ci_q),
        .sub_i (adj_sub_q),
        .r_o   (bcd_r),
        .c_o   (bcd_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            adj_a_q   <= '0;
            adj_b_q   <= '0;
            adj_ci_q  <= 1'b0;
            adj_sub_q <= 1'b0;
            adj_v_q   <= 1'b0;
        end else begin
            adj_a_q   <= adj_a_d;
            adj_b_q   <= adj_b_d;
            adj_ci_q  <= adj_ci_d;
            adj_sub_q <= adj_sub_d;
            adj_v_q   <= adj_v_d;
        end
    end
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
`endif

    always_comb begin : next_state
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_DECIMAL_EN
        adj_a_d   = adj_a_q;
        adj_b_d   = adj_b_q;
        adj_ci_d  = adj_ci_q;
        adj_sub_d = adj_sub_q;
        adj_v_d   = adj_v_q;
`endif
        case (state_q)
            ST_ADJUST: begin
`ifdef ALU_DECIMAL_EN
                // V keeps the binary-intermediate overflow; N/Z follow the corrected digits.
                state_d  = ST_FULL;
                result_d = bcd_r;
                flags_d  = pack_flags(bcd_r, bcd_c, adj_v_q);
`else
                state_d  = ST_IDLE;
`endif
            end
            default: begin
`ifdef ALU_DECIMAL_EN
                if (accept && dec_req) begin
                    state_d   = ST_ADJUST;
                    adj_a_d   = operand1;
                    adj_b_d   = operand2;
                    adj_ci_d  = carry_in;
                    adj_sub_d = (op_number == OPW'(OP_SUB));
                    adj_v_d   = bin_v;
                end else
`endif
                if (accept) begin
                    state_d  = ST_FULL;
                    result_d = bin_r;
                    flags_d  = pack_flags(bin_r, bin_c, bin_v);
                end else if ((state_q == ST_FULL) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign result    = result_q;
    assign flag_n    = flags_q[FLAG_N];
    assign flag_z    = flags_q[FLAG_Z];
    assign flag_c    = flags_q[FLAG_C];
    assign flag_v    = flags_q[FLAG_V];
    assign dbg_state = state_q;

endmodule
